// File: rtl/mp_regfile_pkg.sv
// Shared defaults for the multi-port register file: widths, port counts, zero-register index.
package mp_regfile_pkg;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_NUM_RD   = 2;
    localparam int unsigned RF_NUM_WR   = 2;
    localparam int unsigned RF_ZERO_REG = 0;

    // Number of architectural registers for a given address width.
    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/mp_regfile_scoreboard.sv
// Busy scoreboard: set at issue, cleared at writeback, set wins on collision.
// REGFILE_BYPASS_EN forwards this cycle's issue/writeback onto rd_busy.
module rf_scoreboard
    import mp_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = RF_NUM_RD,
    parameter int unsigned NUM_WR = RF_NUM_WR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
        end
        // A newer producer issued this cycle outranks the writeback.
        if (iss_en && iss_addr != ZERO_ADDR) busy_d[iss_addr] = 1'b1;
        busy_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_busy[p] = busy_q[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (reset && rd_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
                        rd_busy[p] = 1'b0;
                end
                if (iss_en && iss_addr == rd_addr[p*ADDR_W +: ADDR_W]) rd_busy[p] = 1'b1;
            end
`endif
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file with r0 hardwired to zero, busy scoreboard and a debug read tap.
// REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding on the read ports.
module mp_regfile
    import mp_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = RF_NUM_RD,
    parameter int unsigned NUM_WR = RF_NUM_WR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     any_busy,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Ports applied in ascending order so the highest-index writer wins.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != ZERO_ADDR)
                mem_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (rd_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR)
                rd_data[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (reset && rd_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
                        rd_data[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    // Debug tap always shows the stored value, never forwarded data.
    assign dbg_data = (dbg_addr == ZERO_ADDR) ? '0 : mem_q[dbg_addr];

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_busy  (rd_busy),
        .any_busy (any_busy)
    );

endmodule
